// File: rtl/crossbar_switch_alloc.sv
// 5x5 crossbar switch allocator: per-output owner + round-robin pointer, 1-cycle grant latency.
// Optional U-turn path (input p -> output p for p=0..3) enabled by defining XBAR_UTURN_EN.
module crossbar_switch_alloc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  req_i,
  input  logic [14:0] dest_i,
  output logic [4:0]  gnt_o,
  output logic [2:0]  n_cs_sel_demux_o,
  output logic [2:0]  s_cs_sel_demux_o,
  output logic [2:0]  w_cs_sel_demux_o,
  output logic [2:0]  e_cs_sel_demux_o,
  output logic [2:0]  l_cs_sel_demux_o,
  output logic [2:0]  n_cs_sel_mux_o,
  output logic [2:0]  s_cs_sel_mux_o,
  output logic [2:0]  w_cs_sel_mux_o,
  output logic [2:0]  e_cs_sel_mux_o,
  output logic [2:0]  l_cs_sel_mux_o,
  output logic [4:0]  out_vld_o,
  output logic        err_o
);

  logic [4:0]       gnt_q, gnt_d;
  logic [4:0][2:0]  dest_q, dest_d;
  logic [4:0]       own_vld_q, own_vld_d;
  logic [4:0][2:0]  own_q, own_d;
  logic [4:0][2:0]  ptr_q, ptr_d;
  logic [4:0]       seen_q, seen_d;
  logic             err_q, err_d;

  logic [4:0][2:0]  din;
  logic [4:0]       legal;
  logic [4:0]       rel;
  logic [4:0]       elig;
  logic [4:0]       illegal;

  always_comb begin
    for (int unsigned p = 0; p < 5; p++) begin
      din[p]   = dest_i[3*p +: 3];
      legal[p] = (din[p] <= 3'd4);
`ifndef XBAR_UTURN_EN
      if (p < 4 && din[p] == 3'(p)) legal[p] = 1'b0;
`endif
    end
    rel     = gnt_q & ~req_i;
    elig    = req_i & ~gnt_q & legal;
    illegal = req_i & ~gnt_q & ~legal;
  end

  always_comb begin : next_state
    logic        freeing;
    logic        found;
    int unsigned idx;
    int unsigned k;
    gnt_d     = gnt_q;
    dest_d    = dest_q;
    own_vld_d = own_vld_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    freeing   = 1'b0;
    found     = 1'b0;
    idx       = 0;
    k         = 0;

    for (int unsigned p = 0; p < 5; p++) begin
      if (rel[p]) begin
        gnt_d[p]  = 1'b0;
        dest_d[p] = '0;
      end
    end

    // A releasing output is treated as free this edge so it can be handed over with no idle cycle;
    // the releaser cannot win because its request is low.
    for (int unsigned o = 0; o < 5; o++) begin
      freeing = 1'b0;
      for (int unsigned p = 0; p < 5; p++) begin
        if (own_vld_q[o] && own_q[o] == 3'(p) && rel[p]) freeing = 1'b1;
      end
      if (freeing) begin
        own_vld_d[o] = 1'b0;
        own_d[o]     = '0;
      end
      if (!own_vld_q[o] || freeing) begin
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < 5; i++) begin
          idx = 32'(ptr_q[o]) + i;
          if (idx >= 5) idx = idx - 5;
          if (!found && elig[idx] && din[idx] == 3'(o)) begin
            found = 1'b1;
            k     = idx;
          end
        end
        if (found) begin
          own_vld_d[o] = 1'b1;
          own_d[o]     = 3'(k);
          ptr_d[o]     = (k == 4) ? '0 : 3'(k + 1);
          gnt_d[k]     = 1'b1;
          dest_d[k]    = 3'(o);
        end
      end
    end
  end

  // seen_q remembers an already-reported illegal request until req drops.
  always_comb begin
    seen_d = req_i & (seen_q | illegal);
    err_d  = |(illegal & ~seen_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q     <= '0;
      dest_q    <= '0;
      own_vld_q <= '0;
      own_q     <= '0;
      ptr_q     <= '0;
      seen_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      dest_q    <= dest_d;
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
    end
  end

  assign gnt_o            = gnt_q;
  assign out_vld_o        = own_vld_q;
  assign err_o            = err_q;
  assign n_cs_sel_demux_o = dest_q[0];
  assign s_cs_sel_demux_o = dest_q[1];
  assign w_cs_sel_demux_o = dest_q[2];
  assign e_cs_sel_demux_o = dest_q[3];
  assign l_cs_sel_demux_o = dest_q[4];
  assign n_cs_sel_mux_o   = own_q[0];
  assign s_cs_sel_mux_o   = own_q[1];
  assign w_cs_sel_mux_o   = own_q[2];
  assign e_cs_sel_mux_o   = own_q[3];
  assign l_cs_sel_mux_o   = own_q[4];

endmodule

// File: tb/tb_crossbar_switch_alloc.sv
// Scoreboard bench for crossbar_switch_alloc (default build, U-turn disabled).
module tb_crossbar_switch_alloc;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  req_i;
  logic [14:0] dest_i;
  logic [4:0]  gnt_o, out_vld_o;
  logic        err_o;
  logic [2:0]  n_dmx, s_dmx, w_dmx, e_dmx, l_dmx;
  logic [2:0]  n_mux, s_mux, w_mux, e_mux, l_mux;
  logic [14:0] mux_a, dmx_a;

  always #5 clk = ~clk;

  crossbar_switch_alloc dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .dest_i(dest_i), .gnt_o(gnt_o),
    .n_cs_sel_demux_o(n_dmx), .s_cs_sel_demux_o(s_dmx), .w_cs_sel_demux_o(w_dmx),
    .e_cs_sel_demux_o(e_dmx), .l_cs_sel_demux_o(l_dmx),
    .n_cs_sel_mux_o(n_mux), .s_cs_sel_mux_o(s_mux), .w_cs_sel_mux_o(w_mux),
    .e_cs_sel_mux_o(e_mux), .l_cs_sel_mux_o(l_mux),
    .out_vld_o(out_vld_o), .err_o(err_o)
  );

  assign mux_a = {l_mux, e_mux, w_mux, s_mux, n_mux};
  assign dmx_a = {l_dmx, e_dmx, w_dmx, s_dmx, n_dmx};

  typedef struct packed {
    logic [4:0]  gnt;
    logic [4:0]  vld;
    logic [14:0] mux;
    logic [14:0] dmx;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [14:0] pk(input logic [2:0] n, s, w, e, l);
    return {l, e, w, s, n};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_o), 0);
    chk({tag, "_vld"}, 32'(out_vld_o), 0);
    chk({tag, "_mux"}, 32'(mux_a), 0);
    chk({tag, "_dmx"}, 32'(dmx_a), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin : pop
        exp_t e;
        e = q.pop_front();
        chk("gnt", 32'(gnt_o), 32'(e.gnt));
        chk("out_vld", 32'(out_vld_o), 32'(e.vld));
        chk("sel_mux", 32'(mux_a), 32'(e.mux));
        chk("sel_demux", 32'(dmx_a), 32'(e.dmx));
        chk("err", 32'(err_o), 32'(e.err));
      end
    end
  end

  task automatic step(input logic [4:0] r, input logic [14:0] d, input logic [4:0] g,
                      input logic [4:0] v, input logic [14:0] m, input logic [14:0] dm,
                      input logic er);
    @(negedge clk);
    req_i  = r;
    dest_i = d;
    q.push_back({g, v, m, dm, er});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i  = 1'b1;
    req_i  = '0;
    dest_i = '0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i  = 1'b1;
    req_i  = '0;
    dest_i = '0;
    do_reset();

    // Single N->L request.
    step(5'b00001, pk(4,0,0,0,0), 5'b00001, 5'b10000, pk(0,0,0,0,0), pk(4,0,0,0,0), 0);
    step(5'b00000, pk(4,0,0,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 0);

    // N,S,W,E all to L, serialized with zero-idle handoff.
    do_reset();
    step(5'b01111, pk(4,4,4,4,0), 5'b00001, 5'b10000, pk(0,0,0,0,0), pk(4,0,0,0,0), 0);
    step(5'b01111, pk(4,4,4,4,0), 5'b00001, 5'b10000, pk(0,0,0,0,0), pk(4,0,0,0,0), 0);
    step(5'b01110, pk(4,4,4,4,0), 5'b00010, 5'b10000, pk(0,0,0,0,1), pk(0,4,0,0,0), 0);
    step(5'b01100, pk(4,4,4,4,0), 5'b00100, 5'b10000, pk(0,0,0,0,2), pk(0,0,4,0,0), 0);
    step(5'b01000, pk(4,4,4,4,0), 5'b01000, 5'b10000, pk(0,0,0,0,3), pk(0,0,0,4,0), 0);
    step(5'b00000, pk(4,4,4,4,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 0);
    // Pointer now 4: L beats N, then N takes over on L's release edge (wrap 4->0).
    step(5'b10001, pk(4,0,0,0,4), 5'b10000, 5'b10000, pk(0,0,0,0,4), pk(0,0,0,0,4), 0);
    step(5'b00001, pk(4,0,0,0,4), 5'b00001, 5'b10000, pk(0,0,0,0,0), pk(4,0,0,0,0), 0);
    step(5'b00000, pk(4,0,0,0,4), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 0);

    // Full permutation, then dest change during hold is ignored.
    do_reset();
    step(5'b11111, pk(4,0,1,2,3), 5'b11111, 5'b11111, pk(1,2,3,4,0), pk(4,0,1,2,3), 0);
    step(5'b11111, pk(0,0,0,0,0), 5'b11111, 5'b11111, pk(1,2,3,4,0), pk(4,0,1,2,3), 0);
    step(5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 0);

    // Illegal destinations: single pulse, re-pulse only after req drops; W->W U-turn illegal.
    step(5'b00001, pk(7,0,0,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 1);
    step(5'b00001, pk(7,0,0,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 0);
    step(5'b00000, pk(7,0,0,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 0);
    step(5'b00001, pk(7,0,0,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 1);
    step(5'b00100, pk(0,0,2,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 1);
    step(5'b00000, pk(0,0,0,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 0);

    // Three active grants, async reset mid-cycle, regrant on first edge after release.
    step(5'b00111, pk(3,2,0,0,0), 5'b00111, 5'b01101, pk(2,0,1,0,0), pk(3,2,0,0,0), 0);
    @(negedge clk);
    #1 rst_i = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_i = 1'b0;
    q.push_back({5'b00111, 5'b01101, pk(2,0,1,0,0), pk(3,2,0,0,0), 1'b0});
    step(5'b00000, pk(3,2,0,0,0), 5'b00000, 5'b00000, pk(0,0,0,0,0), pk(0,0,0,0,0), 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
